// File: rtl/avg_pkg.sv
// ---------------------------------------------------------------------------
// avg_pkg
//   Shared definitions for the windowed mean filter and its ring buffer:
//   the accumulator width helper, the legal window-depth range and the
//   rounding-mode constants.
//   No ports (package).
// ---------------------------------------------------------------------------
package avg_pkg;

   // Legal range for DEPTH_LOG2; the window holds 2**DEPTH_LOG2 samples.
   localparam int DEPTH_LOG2_MIN = 1;
   localparam int DEPTH_LOG2_MAX = 8;

   // Rounding modes applied before the divide-by-depth shift.
   localparam int ROUND_FLOOR   = 0;
   localparam int ROUND_HALF_UP = 1;

   // A sum of 2**depth_log2 values of data_w bits fits exactly in this width.
   function automatic int acc_width(input int data_w, input int depth_log2);
      return data_w + depth_log2;
   endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// ---------------------------------------------------------------------------
// sample_ring_buffer
//   DEPTH x DATA_W circular sample store. Each write lands at the write
//   pointer, which then advances and wraps. The entry under the pointer
//   (the oldest sample once the window is full) is read combinationally.
//
//   Ports:
//     i_clk      rising-edge clock
//     i_rst      asynchronous active-high reset (pointer only)
//     i_clear    synchronous pointer reset
//     i_wr_en    write i_wr_data at the pointer and advance
//     i_wr_data  sample to store
//     o_rd_data  entry currently under the write pointer
// ---------------------------------------------------------------------------
module sample_ring_buffer
   import avg_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 3
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;

   // Write pointer: the pointer width equals log2(DEPTH), so the natural
   // binary overflow gives the modulo-DEPTH wrap for free.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
      end else if (i_wr_en) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
      end
   end

   // Sample storage is deliberately not reset; the fill counter in the
   // parent masks any stale entries until they have been overwritten.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[r_wr_ptr];

endmodule

// File: rtl/windowed_mean_filter.sv
// ---------------------------------------------------------------------------
// windowed_mean_filter
//   Sliding-window moving average over the last 2**DEPTH_LOG2 accepted
//   samples of an unsigned stream, with a running accumulator, optional
//   warm-up output (PRIME) and optional round-half-up (ROUND).
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     clear      synchronous flush of the window state
//     in_valid   in_data is accepted this cycle
//     in_data    unsigned sample
//     out_valid  single-cycle pulse, out_mean holds a new result
//     out_mean   window mean (holds while out_valid is low)
//     win_full   a full window of samples is held since reset/clear
// ---------------------------------------------------------------------------
module windowed_mean_filter
   import avg_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int PRIME      = 0,
   parameter int ROUND      = ROUND_FLOOR
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_mean,
   output logic              win_full
);

   localparam int ACC_W          = acc_width(DATA_W, DEPTH_LOG2);
   localparam int ROUND_BIAS_INT = (ROUND == ROUND_HALF_UP) ? (1 << (DEPTH_LOG2 - 1)) : 0;

   localparam logic [ACC_W:0]      ROUND_BIAS = (ACC_W + 1)'(ROUND_BIAS_INT);
   localparam logic [ACC_W:0]      MEAN_MAX   = {{(DEPTH_LOG2 + 1){1'b0}}, {DATA_W{1'b1}}};
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [ACC_W-1:0]      r_acc;
   logic [DEPTH_LOG2:0]   r_fill;
   logic                  r_out_valid;
   logic [DATA_W-1:0]     r_out_mean;
   logic                  r_win_full;

   logic                  w_wr_en;
   logic [DATA_W-1:0]     w_rd_data;
   logic                  w_full_now;
   logic [DEPTH_LOG2:0]   w_fill_n;
   logic [ACC_W-1:0]      w_in_ext;
   logic [ACC_W-1:0]      w_oldest_ext;
   logic [ACC_W-1:0]      w_acc_n;
   logic [ACC_W:0]        w_sum;
   logic [ACC_W:0]        w_shifted;
   logic [DATA_W-1:0]     w_mean;
   logic                  w_emit;

   // A clear in the same cycle as a sample discards that sample entirely,
   // so the buffer must not see the write either.
   assign w_wr_en = in_valid & ~clear;

   sample_ring_buffer #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ring (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_clear   (clear),
      .i_wr_en   (w_wr_en),
      .i_wr_data (in_data),
      .o_rd_data (w_rd_data)
   );

   // Next accumulator value: add the new sample and, once the window is
   // full, subtract the sample it displaces. While filling, the slot under
   // the pointer is stale and is treated as zero. The sum never exceeds
   // DEPTH * (2**DATA_W - 1), so ACC_W bits cannot wrap.
   assign w_full_now   = (r_fill == DEPTH_CNT);
   assign w_fill_n     = w_full_now ? r_fill : r_fill + 1'b1;
   assign w_in_ext     = {{DEPTH_LOG2{1'b0}}, in_data};
   assign w_oldest_ext = w_full_now ? {{DEPTH_LOG2{1'b0}}, w_rd_data} : '0;
   assign w_acc_n      = r_acc + w_in_ext - w_oldest_ext;

   // Rounding bias is added one bit wider than the accumulator so the
   // largest possible sum plus bias cannot wrap before the divide.
   assign w_sum     = {1'b0, w_acc_n} + ROUND_BIAS;
   assign w_shifted = w_sum >> DEPTH_LOG2;
   assign w_mean    = (w_shifted > MEAN_MAX) ? {DATA_W{1'b1}} : w_shifted[DATA_W-1:0];

   // In warm-up mode every accepted sample produces a result; otherwise
   // results start only once the window is full.
   assign w_emit = (PRIME != 0) || (w_fill_n == DEPTH_CNT);

   // Window state and output registers. clear wins over in_valid and leaves
   // out_mean untouched; idle cycles hold everything except the valid pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_fill      <= '0;
         r_out_valid <= 1'b0;
         r_out_mean  <= '0;
         r_win_full  <= 1'b0;
      end else if (clear) begin
         r_acc       <= '0;
         r_fill      <= '0;
         r_out_valid <= 1'b0;
         r_win_full  <= 1'b0;
      end else if (in_valid) begin
         r_acc       <= w_acc_n;
         r_fill      <= w_fill_n;
         r_win_full  <= (w_fill_n == DEPTH_CNT);
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_out_mean <= w_mean;
         end
      end else begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_mean  = r_out_mean;
   assign win_full  = r_win_full;

endmodule

// File: tb/tb_windowed_mean_filter.sv
// ---------------------------------------------------------------------------
// tb_windowed_mean_filter
//   Drives one stimulus stream into two filter instances (floor / no warm-up
//   and round-half-up / warm-up) and scores both against a window model.
// ---------------------------------------------------------------------------
module tb_windowed_mean_filter;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       inValid;
   logic [7:0] inData;

   logic       outValidA, outValidB;
   logic [7:0] outMeanA, outMeanB;
   logic       winFullA, winFullB;

   int compared   = 0;
   int mismatched = 0;

   int window[$];
   int expA[$];
   int expB[$];
   int lastA = 0;
   int lastB = 0;

   windowed_mean_filter #(
      .DATA_W     (8),
      .DEPTH_LOG2 (3),
      .PRIME      (0),
      .ROUND      (0)
   ) dutA (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (inValid),
      .in_data   (inData),
      .out_valid (outValidA),
      .out_mean  (outMeanA),
      .win_full  (winFullA)
   );

   windowed_mean_filter #(
      .DATA_W     (8),
      .DEPTH_LOG2 (3),
      .PRIME      (1),
      .ROUND      (1)
   ) dutB (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (inValid),
      .in_data   (inData),
      .out_valid (outValidB),
      .out_mean  (outMeanB),
      .win_full  (winFullB)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkValue(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Mean of the current window: the window sum divided by the full depth,
   // missing samples counting as zero, with optional round-half-up.
   function automatic int windowMean(input bit roundUp);
      int sum = 0;
      int m;
      foreach (window[i]) sum += window[i];
      m = roundUp ? (sum + DEPTH / 2) / DEPTH : sum / DEPTH;
      return (m > 255) ? 255 : m;
   endfunction

   // One clock of stimulus: update the model with what this edge will do,
   // queue the expected results, then step past the edge and check win_full.
   task automatic applyStimulus(input bit v, input int d, input bit c);
      inValid = v;
      inData  = 8'(d);
      clear   = c;
      if (c) begin
         window.delete();
      end else if (v) begin
         window.push_back(d);
         if (window.size() > DEPTH) void'(window.pop_front());
         if (window.size() == DEPTH) expA.push_back(windowMean(1'b0));
         expB.push_back(windowMean(1'b1));
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      clear   = 1'b0;
      checkOutput();
   endtask

   task automatic checkOutput();
      checkValue("A_win_full", int'(winFullA), int'(window.size() == DEPTH));
      checkValue("B_win_full", int'(winFullB), int'(window.size() == DEPTH));
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      #2;
      checkValue("rst_A_valid", int'(outValidA), 0);
      checkValue("rst_A_mean", int'(outMeanA), 0);
      checkValue("rst_A_full", int'(winFullA), 0);
      checkValue("rst_B_valid", int'(outValidB), 0);
      checkValue("rst_B_mean", int'(outMeanB), 0);
      checkValue("rst_B_full", int'(winFullB), 0);
      window.delete();
      lastA = 0;
      lastB = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: pops an expected result on every valid pulse and otherwise
   // checks that the mean output holds its last emitted value.
   always @(negedge clk) begin
      if (outValidA) begin
         if (expA.size() == 0) checkValue("A_unexpected_valid", 1, 0);
         else begin
            lastA = expA.pop_front();
            checkValue("A_mean", int'(outMeanA), lastA);
         end
      end else begin
         checkValue("A_hold", int'(outMeanA), lastA);
      end
      if (outValidB) begin
         if (expB.size() == 0) checkValue("B_unexpected_valid", 1, 0);
         else begin
            lastB = expB.pop_front();
            checkValue("B_mean", int'(outMeanB), lastB);
         end
      end else begin
         checkValue("B_hold", int'(outMeanB), lastB);
      end
   end

   initial begin
      clear   = 1'b0;
      inValid = 1'b0;
      inData  = '0;

      // Reset asserted before any clock edge.
      pulseReset();

      // A full window of 100, then a window of 200 sliding in.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 100, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkValue("s2_A_mean_100", int'(outMeanA), 100);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 200, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkValue("s3_A_mean_200", int'(outMeanA), 200);
      checkValue("s3_B_mean_200", int'(outMeanB), 200);

      // Full-scale samples separated by idle gaps.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 255, 1'b0);
         applyStimulus(1'b0, 0, 1'b0);
         applyStimulus(1'b0, 0, 1'b0);
      end
      checkValue("s4_A_mean_255", int'(outMeanA), 255);

      // Clear together with a sample, then one sample of 80.
      applyStimulus(1'b1, 80, 1'b1);
      applyStimulus(1'b1, 80, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkValue("s5_B_mean_10", int'(outMeanB), 10);

      // Reset part-way through a window, then a fresh window of 40.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 250, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      pulseReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 40, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkValue("s6_A_mean_40", int'(outMeanA), 40);

      // Randomised traffic with occasional clears.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                       $urandom_range(0, 31) == 0);
      end
      applyStimulus(1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);

      checkValue("A_results_drained", expA.size(), 0);
      checkValue("B_results_drained", expB.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
